// File: rtl/msrh_fpu_pkg.sv
// -----------------------------------------------------------------------------
// msrh_fpu_pkg
//   Shared types for the FP completion queue.
//   - cmpl_state_t : lifecycle of a queue entry (FREE -> ISSUED -> DONE -> FREE)
//   - cmpl_entry_t : per-entry bookkeeping plus the captured, formatted result
//   - NAN_BOX_HI   : upper word used to NaN-box single-precision FP results
// -----------------------------------------------------------------------------
package msrh_fpu_pkg;

  // Storage widths of the entry payload. They match the queue's default
  // TAG_W / XLEN, so every stored bit is read at the default configuration.
  // A narrower TAG_W or XLEN zero-extends into these fields.
  localparam int unsigned CMPL_TAG_W = 7;
  localparam int unsigned XLEN_MAX   = 64;

  localparam logic [31:0] NAN_BOX_HI = 32'hFFFF_FFFF;

  // FREE must stay at encoding 0 so a cleared entry reads as free.
  typedef enum logic [1:0] {
    CMPL_FREE   = 2'd0,
    CMPL_ISSUED = 2'd1,
    CMPL_DONE   = 2'd2
  } cmpl_state_t;

  typedef struct packed {
    cmpl_state_t           state;
    logic                  kill;     // flushed: consume the result, never write it back
    logic [CMPL_TAG_W-1:0] tag;
    logic                  size_dw;  // 1 = double, 0 = single
    logic                  fp_dst;   // 1 = FP register, 0 = integer register
    logic [XLEN_MAX-1:0]   result;   // already formatted for the destination
    logic [4:0]            fflags;
  } cmpl_entry_t;

endpackage

// File: rtl/msrh_fpu_result_fmt.sv
// -----------------------------------------------------------------------------
// msrh_fpu_result_fmt
//   Combinational result formatter applied when a wrapper result is captured.
//   XLEN=64:
//     size_dw=1              -> result passed through
//     size_dw=0, fp_dst=1    -> NaN-boxed single  {FFFF_FFFF, r[31:0]}
//     size_dw=0, fp_dst=0    -> sign-extended word {{32{r[31]}}, r[31:0]}
//   XLEN=32: result passed through.
// Ports:
//   i_result  [XLEN] raw wrapper result
//   i_size_dw        operation precision
//   i_fp_dst         destination register class
//   o_result  [XLEN] formatted result
// -----------------------------------------------------------------------------
module msrh_fpu_result_fmt
  import msrh_fpu_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0] i_result,
  input  logic            i_size_dw,
  input  logic            i_fp_dst,
  output logic [XLEN-1:0] o_result
);

  if (XLEN == 64) begin : g_xlen64
    always_comb begin
      if (i_size_dw) begin
        o_result = i_result;
      end else if (i_fp_dst) begin
        o_result = {NAN_BOX_HI, i_result[31:0]};
      end else begin
        o_result = {{32{i_result[31]}}, i_result[31:0]};
      end
    end
  end else begin : g_xlen32
    // Nothing to widen on a 32-bit datapath; the class inputs are irrelevant.
    logic unused_fmt_ctrl;
    assign unused_fmt_ctrl = i_size_dw ^ i_fp_dst;
    assign o_result        = i_result;
  end

endmodule

// File: rtl/msrh_fpu_cmpl_queue.sv
// -----------------------------------------------------------------------------
// msrh_fpu_cmpl_queue
//   In-order completion queue around the FP execution wrapper. Issues are
//   admitted when the wrapper is ready and a slot is free; the untagged,
//   in-order wrapper results are paired with the oldest ISSUED entry,
//   formatted, and held until the writeback port accepts them.
//   Three wrap-bit pointers walk the ring:
//     head : next entry to write back   [head, done) are DONE
//     done : oldest ISSUED entry        [done, tail) are ISSUED
//     tail : next free entry
// Ports:
//   i_clk, i_reset                 clock, synchronous active-high reset
//   i_issue_* / o_issue_ready      issue request and handshake
//   o_fpu_valid, i_fpu_ready       request side of the wrapper
//   i_fpu_valid/result/fflags      wrapper result (in order, untagged)
//   o_wb_* / i_wb_ready            writeback request and grant
//   i_flush                        kill every outstanding op
//   o_protocol_err                 sticky: result with no ISSUED entry
// -----------------------------------------------------------------------------
module msrh_fpu_cmpl_queue
  import msrh_fpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 7,
  parameter int unsigned XLEN  = 64
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_issue_valid,
  output logic             o_issue_ready,
  input  logic [TAG_W-1:0] i_issue_tag,
  input  logic             i_issue_size_dw,
  input  logic             i_issue_fp_dst,
  output logic             o_fpu_valid,
  input  logic             i_fpu_ready,
  input  logic             i_fpu_valid,
  input  logic [XLEN-1:0]  i_fpu_result,
  input  logic [4:0]       i_fpu_fflags,
  output logic             o_wb_valid,
  input  logic             i_wb_ready,
  output logic [TAG_W-1:0] o_wb_tag,
  output logic [XLEN-1:0]  o_wb_result,
  output logic [4:0]       o_wb_fflags,
  output logic             o_wb_fp_dst,
  input  logic             i_flush,
  output logic             o_protocol_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  cmpl_entry_t      entries_q [DEPTH];
  cmpl_entry_t      entries_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] done_q, done_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic             perr_q, perr_d;

  logic [IDX_W-1:0] head_idx, done_idx, tail_idx;
  logic [PTR_W-1:0] count;
  logic             full;
  logic             has_issued;
  logic             issue_fire;
  logic             cmpl_fire;
  logic             wb_fire;
  logic             silent_free;
  cmpl_entry_t      head_e, done_e;
  logic [XLEN-1:0]  fmt_result;

  assign head_idx = head_q[IDX_W-1:0];
  assign done_idx = done_q[IDX_W-1:0];
  assign tail_idx = tail_q[IDX_W-1:0];
  assign head_e   = entries_q[head_idx];
  assign done_e   = entries_q[done_idx];

  // Occupancy comes from registered pointers only, so a pop in this cycle
  // does not open a slot for an issue in the same cycle.
  assign count      = tail_q - head_q;
  assign full       = (count == PTR_W'(DEPTH));
  assign has_issued = (done_q != tail_q);

  assign o_issue_ready = i_fpu_ready & ~full & ~i_flush & ~i_reset;
  assign issue_fire    = i_issue_valid & o_issue_ready;
  assign o_fpu_valid   = issue_fire;

  assign cmpl_fire = i_fpu_valid & has_issued;

  assign o_wb_valid  = (head_e.state == CMPL_DONE) & ~head_e.kill & ~i_flush & ~i_reset;
  assign wb_fire     = o_wb_valid & i_wb_ready;
  assign silent_free = (head_e.state == CMPL_DONE) & head_e.kill;

  assign o_wb_tag       = i_reset ? '0 : head_e.tag[TAG_W-1:0];
  assign o_wb_result    = i_reset ? '0 : head_e.result[XLEN-1:0];
  assign o_wb_fflags    = i_reset ? '0 : head_e.fflags;
  assign o_wb_fp_dst    = i_reset ? 1'b0 : head_e.fp_dst;
  assign o_protocol_err = perr_q & ~i_reset;

  // Formatting uses the class recorded at issue for the entry being completed.
  msrh_fpu_result_fmt #(
    .XLEN (XLEN)
  ) u_result_fmt (
    .i_result  (i_fpu_result),
    .i_size_dw (done_e.size_dw),
    .i_fp_dst  (done_e.fp_dst),
    .o_result  (fmt_result)
  );

  always_comb begin
    // NOTE: every _d starts from its _q, so no branch leaves a signal
    // unassigned and no latch is inferred.
    entries_d = entries_q;
    head_d    = head_q;
    done_d    = done_q;
    tail_d    = tail_q;
    perr_d    = perr_q | (i_fpu_valid & ~has_issued);

    // Writeback side: a flush drops every DONE entry at once and marks the
    // in-flight ones; otherwise the head retires (granted or killed).
    if (i_flush) begin
      head_d = done_q;
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (entries_q[i].state == CMPL_DONE) begin
          entries_d[i].state = CMPL_FREE;
        end else if (entries_q[i].state == CMPL_ISSUED) begin
          entries_d[i].kill = 1'b1;
        end
      end
    end else if (wb_fire || silent_free) begin
      entries_d[head_idx].state = CMPL_FREE;
      head_d                    = head_q + 1'b1;
    end

    // Completion keeps the kill bit, so a result landing in the flush cycle
    // is captured and later freed silently.
    if (cmpl_fire) begin
      entries_d[done_idx].state             = CMPL_DONE;
      entries_d[done_idx].result            = '0;
      entries_d[done_idx].result[XLEN-1:0]  = fmt_result;
      entries_d[done_idx].fflags            = i_fpu_fflags;
      done_d                                = done_q + 1'b1;
    end

    if (issue_fire) begin
      entries_d[tail_idx].state   = CMPL_ISSUED;
      entries_d[tail_idx].kill    = 1'b0;
      entries_d[tail_idx].tag     = CMPL_TAG_W'(i_issue_tag);
      entries_d[tail_idx].size_dw = i_issue_size_dw;
      entries_d[tail_idx].fp_dst  = i_issue_fp_dst;
      entries_d[tail_idx].result  = '0;
      entries_d[tail_idx].fflags  = '0;
      tail_d                      = tail_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      head_q <= '0;
      done_q <= '0;
      tail_q <= '0;
      perr_q <= 1'b0;
      // NOTE: the entry array is reset because its state field must return to
      // FREE; clearing the payload too keeps the data outputs at zero.
      for (int i = 0; i < int'(DEPTH); i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      head_q    <= head_d;
      done_q    <= done_d;
      tail_q    <= tail_d;
      perr_q    <= perr_d;
      entries_q <= entries_d;
    end
  end

endmodule
